// File: rtl/rs_dec_syndrome_if.sv
// Symbol-stream and syndrome bundle between the received-symbol source,
// rs_dec_syndrome and the downstream Euclid stage.
interface rs_dec_syndrome_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_sof;
    logic [7:0] o_s0;
    logic [7:0] o_s1;
    logic [7:0] o_s2;
    logic [7:0] o_s3;
    logic       o_synd_sync;
    logic       o_nonzero;
    logic       o_frame_err;

    modport master (
        output i_data, i_valid, i_sof,
        input  o_s0, o_s1, o_s2, o_s3, o_synd_sync, o_nonzero, o_frame_err
    );

    modport slave (
        input  i_data, i_valid, i_sof,
        output o_s0, o_s1, o_s2, o_s3, o_synd_sync, o_nonzero, o_frame_err
    );
endinterface

// File: rtl/rs_dec_syndrome.sv
// Symbol-serial syndrome computer S0..S3 = r(alpha^0..alpha^3) over GF(2^8),
// field polynomial 0x11D, highest-degree symbol first (Horner evaluation).
module rs_dec_syndrome #(
    parameter int CW_LEN = 32
) (
    input logic              i_clk,
    input logic              i_rst,
    rs_dec_syndrome_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACC   = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(CW_LEN - 1);

    // Multiply by alpha: shift left, fold the x^8 carry back with 0x1D.
    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    logic [0:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_q   [4];
    logic [7:0] acc_d   [4];
    logic [7:0] synd_q  [4];
    logic [7:0] synd_d  [4];
    logic [7:0] horner  [4];
    logic       nz_q, nz_d;
    logic       sync_q, sync_d;
    logic       ferr_q, ferr_d;

    assign horner[0] = acc_q[0] ^ bus.i_data;
    assign horner[1] = mul_alpha(acc_q[1]) ^ bus.i_data;
    assign horner[2] = mul_alpha(mul_alpha(acc_q[2])) ^ bus.i_data;
    assign horner[3] = mul_alpha(mul_alpha(mul_alpha(acc_q[3]))) ^ bus.i_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        synd_d  = synd_q;
        nz_d    = nz_q;
        sync_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.i_valid && bus.i_sof) begin
                for (int j = 0; j < 4; j++) acc_d[j] = bus.i_data;
                cnt_d   = 8'd1;
                state_d = ST_ACC;
            end
        end else if (bus.i_valid) begin
            if (bus.i_sof) begin
                // Early restart: drop the partial word, published syndromes untouched.
                for (int j = 0; j < 4; j++) acc_d[j] = bus.i_data;
                cnt_d  = 8'd1;
                ferr_d = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
                synd_d  = horner;
                nz_d    = |(horner[0] | horner[1] | horner[2] | horner[3]);
                sync_d  = 1'b1;
                cnt_d   = 8'd0;
                acc_d   = '{default: 8'h00};
                state_d = ST_IDLE;
            end else begin
                acc_d = horner;
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            acc_q   <= '{default: 8'h00};
            synd_q  <= '{default: 8'h00};
            nz_q    <= 1'b0;
            sync_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            synd_q  <= synd_d;
            nz_q    <= nz_d;
            sync_q  <= sync_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.o_s0        = synd_q[0];
    assign bus.o_s1        = synd_q[1];
    assign bus.o_s2        = synd_q[2];
    assign bus.o_s3        = synd_q[3];
    assign bus.o_nonzero   = nz_q;
    assign bus.o_synd_sync = sync_q;
    assign bus.o_frame_err = ferr_q;
endmodule

// File: tb/tb_rs_dec_syndrome.sv
// Bench for rs_dec_syndrome: table of single-symbol codewords with known
// syndromes, scoreboard of expected syndromes popped on each sync pulse.
module tb_rs_dec_syndrome;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    rs_dec_syndrome_if bus ();

    rs_dec_syndrome #(.CW_LEN(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic        nz;
    } exp_t;

    typedef struct {
        int          pos;
        logic [7:0]  val;
        logic [31:0] s;
        logic        nz;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[6];
    logic [7:0] cw[N];
    int pass_cnt = 0;
    int total    = 0;
    int sync_cnt = 0;
    int ferr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Direct power-sum evaluation: S_j = sum r_i * alpha^(j*deg_i).
    function automatic exp_t model();
        exp_t       e;
        logic [7:0] sj;
        logic [7:0] pw;
        e.s = 32'h0;
        for (int j = 0; j < 4; j++) begin
            sj = 8'h00;
            for (int i = 0; i < N; i++) begin
                pw = 8'h01;
                repeat (j * (N - 1 - i)) pw = gmul(pw, 8'h02);
                sj ^= gmul(cw[i], pw);
            end
            e.s[31-8*j -: 8] = sj;
        end
        e.nz = |e.s;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_synd_sync) begin
            sync_cnt++;
            if (sb.size() == 0) begin
                check("synd_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("synd_val", {bus.o_s0, bus.o_s1, bus.o_s2, bus.o_s3}, e.s);
                check("synd_nz", {31'b0, bus.o_nonzero}, {31'b0, e.nz});
            end
        end
    end

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            bus.i_sof   = 1'b0;
            bus.i_data  = 8'($urandom);
        end
    endtask

    task automatic drive_sym(input logic [7:0] d, input logic sof);
        @(posedge clk); #1;
        bus.i_valid = 1'b1;
        bus.i_sof   = sof;
        bus.i_data  = d;
    endtask

    task automatic send_cw(input int max_gap, input exp_t e);
        for (int i = 0; i < N; i++) begin
            if (i > 0 && max_gap > 0) drive_idle($urandom_range(1, max_gap));
            if (i == N - 1) sb.push_back(e);
            drive_sym(cw[i], i == 0);
        end
    endtask

    task automatic single_cw(input int pos, input logic [7:0] val);
        for (int i = 0; i < N; i++) cw[i] = 8'h00;
        cw[pos] = val;
    endtask

    function automatic logic [31:0] outs();
        return {bus.o_s0, bus.o_s1, bus.o_s2, bus.o_s3};
    endfunction

    function automatic logic [31:0] flags();
        return {29'b0, bus.o_synd_sync, bus.o_nonzero, bus.o_frame_err};
    endfunction

    initial begin
        exp_t e;
        vt[0] = '{pos: 0,  val: 8'h00, s: 32'h00000000, nz: 1'b0};
        vt[1] = '{pos: 31, val: 8'h01, s: 32'h01010101, nz: 1'b1};
        vt[2] = '{pos: 31, val: 8'h05, s: 32'h05050505, nz: 1'b1};
        vt[3] = '{pos: 30, val: 8'h01, s: 32'h01020408, nz: 1'b1};
        vt[4] = '{pos: 29, val: 8'h01, s: 32'h01041040, nz: 1'b1};
        vt[5] = '{pos: 24, val: 8'h01, s: 32'h01801375, nz: 1'b1};

        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_synd", outs(), 32'h0);
        check("rst_flags", flags(), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            single_cw(vt[k].pos, vt[k].val);
            e.s  = vt[k].s;
            e.nz = vt[k].nz;
            send_cw(0, e);
            drive_idle(3);
        end
        drive_idle(5);
        check("table_syncs", sync_cnt, 6);
        check("table_ferr", ferr_cnt, 0);
        check("hold_synd", outs(), 32'h01801375);
        check("hold_nz", {31'b0, bus.o_nonzero}, 32'd1);

        // Stray symbols without sof, then a gapped degree-1 codeword.
        drive_sym(8'hA5, 1'b0);
        drive_sym(8'h3C, 1'b0);
        drive_idle(2);
        drive_sym(8'hFF, 1'b0);
        single_cw(30, 8'h01);
        e.s = 32'h01020408; e.nz = 1'b1;
        send_cw(7, e);
        drive_idle(4);
        check("gap_syncs", sync_cnt, 7);
        check("gap_ferr", ferr_cnt, 0);

        // Partial word cut short by an early sof.
        for (int i = 0; i < 10; i++) drive_sym(8'($urandom_range(1, 255)), i == 0);
        drive_idle(1);
        check("partial_hold", outs(), 32'h01020408);
        single_cw(31, 8'h01);
        e.s = 32'h01010101; e.nz = 1'b1;
        send_cw(0, e);
        drive_idle(4);
        check("restart_ferr", ferr_cnt, 1);
        check("restart_syncs", sync_cnt, 8);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) cw[i] = 8'($urandom);
            send_cw(2, model());
            drive_idle(3);
        end
        check("rand_syncs", sync_cnt, 10);

        // Back-to-back words, then reset in the middle of a third.
        single_cw(30, 8'h01);
        e.s = 32'h01020408; e.nz = 1'b1;
        send_cw(0, e);
        send_cw(0, e);
        for (int i = 0; i < 12; i++) drive_sym(8'($urandom_range(1, 255)), i == 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("b2b_syncs", sync_cnt, 12);
        check("midrst_synd", outs(), 32'h0);
        check("midrst_flags", flags(), 32'h0);
        drive_idle(40);
        check("midrst_nosync", sync_cnt, 12);
        check("midrst_ferr", ferr_cnt, 1);

        single_cw(29, 8'h01);
        e.s = 32'h01041040; e.nz = 1'b1;
        send_cw(0, e);
        drive_idle(4);
        check("post_rst_syncs", sync_cnt, 13);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
